// File: rtl/acappella_pkg.sv
// Shared types and constants for the acappella audio playback path.
package acappella_pkg;

    typedef struct packed {
        logic signed [15:0] left;
        logic signed [15:0] right;
    } stereo_sample_t;

    localparam int OUT_FIFO_DEPTH = 16;
    localparam int UNDERRUN_W     = 16;

    function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
        if (v == {UNDERRUN_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(UNDERRUN_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/sample_ram.sv
// DEPTH x 32 sample storage: synchronous write, asynchronous read from a register array.
module sample_ram
    import acappella_pkg::*;
#(
    parameter int DEPTH = OUT_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  stereo_sample_t wr_data,
    input  logic [AW-1:0]  rd_addr,
    output stereo_sample_t rd_data
);

    stereo_sample_t mem_r [DEPTH];

    // Sample write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/stereo_out_fifo.sv
// Elastic stereo sample buffer feeding independent left/right DAC sinks,
// with a saturating count of DAC starvation intervals.
module stereo_out_fifo
    import acappella_pkg::*;
#(
    parameter int DEPTH = OUT_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic [15:0]           to_dac_left_channel_data,
    output logic                  to_dac_left_channel_valid,
    input  logic                  to_dac_left_channel_ready,
    output logic [15:0]           to_dac_right_channel_data,
    output logic                  to_dac_right_channel_valid,
    input  logic                  to_dac_right_channel_ready,
    output logic [AW:0]           o_level,
    output logic [UNDERRUN_W-1:0] o_underrun_cnt
);

    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [AW:0]           level_r;
    logic                  left_done_r;
    logic                  right_done_r;
    logic                  starved_r;
    logic [UNDERRUN_W-1:0] underrun_cnt_r;
    stereo_sample_t        hold_r;

    stereo_sample_t head_s;
    logic           nonempty_s;
    logic           push_s;
    logic           pop_s;
    logic           left_acc_s;
    logic           right_acc_s;
    logic           starved_s;

    sample_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (stereo_sample_t'(in_data)),
        .rd_addr (rd_ptr_r),
        .rd_data (head_s)
    );

    // Handshake decode; every output here depends only on state and flush.
    always_comb begin
        nonempty_s                 = (level_r != LEVEL_ZERO);
        in_ready                   = (level_r != LEVEL_FULL) && !i_flush;
        to_dac_left_channel_valid  = nonempty_s && !left_done_r && !i_flush;
        to_dac_right_channel_valid = nonempty_s && !right_done_r && !i_flush;
        push_s                     = in_valid && in_ready;
        left_acc_s                 = to_dac_left_channel_valid && to_dac_left_channel_ready;
        right_acc_s                = to_dac_right_channel_valid && to_dac_right_channel_ready;
        pop_s                      = nonempty_s && !i_flush
                                     && (left_done_r || left_acc_s)
                                     && (right_done_r || right_acc_s);
        starved_s                  = !nonempty_s && to_dac_left_channel_ready;
        // Empty FIFO keeps showing the last presented sample (zero after reset).
        if (nonempty_s) begin
            to_dac_left_channel_data  = head_s.left;
            to_dac_right_channel_data = head_s.right;
        end else begin
            to_dac_left_channel_data  = hold_r.left;
            to_dac_right_channel_data = hold_r.right;
        end
    end

    // Pointers, level and per-half delivery flags
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            level_r      <= LEVEL_ZERO;
            left_done_r  <= 1'b0;
            right_done_r <= 1'b0;
        end else if (i_flush) begin
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            level_r      <= LEVEL_ZERO;
            left_done_r  <= 1'b0;
            right_done_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r     <= rd_ptr_r + PTR_ONE;
                left_done_r  <= 1'b0;
                right_done_r <= 1'b0;
            end else begin
                left_done_r  <= left_done_r | left_acc_s;
                right_done_r <= right_done_r | right_acc_s;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Starvation edge detect and saturating interval counter
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            starved_r      <= 1'b0;
            underrun_cnt_r <= {UNDERRUN_W{1'b0}};
        end else if (i_flush) begin
            starved_r      <= 1'b0;
            underrun_cnt_r <= {UNDERRUN_W{1'b0}};
        end else begin
            starved_r <= starved_s;
            if (starved_s && !starved_r) begin
                underrun_cnt_r <= sat_inc(underrun_cnt_r);
            end
        end
    end

    // Capture of the presented head for the empty-FIFO hold value
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            hold_r <= '{left: 16'sd0, right: 16'sd0};
        end else if (nonempty_s) begin
            hold_r <= head_s;
        end
    end

    assign o_level        = level_r;
    assign o_underrun_cnt = underrun_cnt_r;

endmodule

// File: tb/tb_stereo_out_fifo.sv
// Self-checking bench for stereo_out_fifo: directed scenarios plus randomized
// traffic compared against a transaction-level queue model.
module tb_stereo_out_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_flush;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic [15:0]   l_data;
    logic          l_valid;
    logic          l_rdy;
    logic [15:0]   r_data;
    logic          r_valid;
    logic          r_rdy;
    logic [AW:0]   o_level;
    logic [15:0]   o_underrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents, per-half delivery state, starvation history.
    logic [31:0] q[$];
    bit          m_ld, m_rd, m_sp;
    int unsigned m_cnt;

    stereo_out_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk                      (i_clk),
        .i_rst                      (i_rst),
        .i_flush                    (i_flush),
        .in_valid                   (in_valid),
        .in_data                    (in_data),
        .in_ready                   (in_ready),
        .to_dac_left_channel_data   (l_data),
        .to_dac_left_channel_valid  (l_valid),
        .to_dac_left_channel_ready  (l_rdy),
        .to_dac_right_channel_data  (r_data),
        .to_dac_right_channel_valid (r_valid),
        .to_dac_right_channel_ready (r_rdy),
        .o_level                    (o_level),
        .o_underrun_cnt             (o_underrun_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic model_reset();
        q.delete();
        m_ld  = 1'b0;
        m_rd  = 1'b0;
        m_sp  = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_update();
        int lvl;
        bit la, ra;
        lvl = q.size();
        if (!i_rst || i_flush) begin
            model_reset();
            return;
        end
        la = (lvl > 0) && !m_ld && l_rdy;
        ra = (lvl > 0) && !m_rd && r_rdy;
        if (lvl == 0 && l_rdy) begin
            if (!m_sp && m_cnt != 32'hFFFF) m_cnt++;
            m_sp = 1'b1;
        end else begin
            m_sp = 1'b0;
        end
        if (lvl > 0 && (m_ld || la) && (m_rd || ra)) begin
            void'(q.pop_front());
            m_ld = 1'b0;
            m_rd = 1'b0;
        end else begin
            m_ld = m_ld | la;
            m_rd = m_rd | ra;
        end
        if (in_valid && lvl != DEPTH) q.push_back(in_data);
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_update();
        #1;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (l_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lvalid: got %b want 0", l_valid); end
        n_checks++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", r_valid); end
        n_checks++; if (o_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", o_level); end
        n_checks++; if (o_underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", o_underrun_cnt); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if ({l_data, r_data} !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {l_data, r_data}); end
        tick();
        tick();
        i_rst = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 32'h1234ABCD; l_rdy = 1'b1; r_rdy = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if ({l_valid, r_valid} !== 2'b11) begin n_fail++; $display("FAIL single_valids: got %b want 11", {l_valid, r_valid}); end
        n_checks++; if (l_data !== 16'h1234) begin n_fail++; $display("FAIL single_left: got %h want 1234", l_data); end
        n_checks++; if (r_data !== 16'hABCD) begin n_fail++; $display("FAIL single_right: got %h want abcd", r_data); end
        tick();
        n_checks++; if (o_level !== 5'd0) begin n_fail++; $display("FAIL single_level_after_pop: got %0d want 0", o_level); end
        l_rdy = 1'b0; r_rdy = 1'b0;
    endtask

    task automatic test_fill_split();
        push_n(DEPTH);
        #1;
        n_checks++; if (o_level !== 5'd16) begin n_fail++; $display("FAIL fill_level: got %0d want 16", o_level); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b1; in_data = 32'hFFFF0000; l_rdy = 1'b1;
        tick();
        in_valid = 1'b0; l_rdy = 1'b0;
        #1;
        n_checks++; if ({l_valid, r_valid} !== 2'b01) begin n_fail++; $display("FAIL split_valids: got %b want 01", {l_valid, r_valid}); end
        n_checks++; if (o_level !== 5'd16) begin n_fail++; $display("FAIL split_level: got %0d want 16", o_level); end
        r_rdy = 1'b1;
        tick();
        r_rdy = 1'b0;
        #1;
        n_checks++; if (o_level !== 5'd15) begin n_fail++; $display("FAIL split_pop_level: got %0d want 15", o_level); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL split_in_ready: got %b want 1", in_ready); end
        push_n(1);
        // Full with a pop in the same cycle: no bypass, so the offered sample is dropped.
        in_valid = 1'b1; in_data = 32'h55AA55AA; l_rdy = 1'b1; r_rdy = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (o_level !== 5'd15) begin n_fail++; $display("FAIL full_pop_no_bypass: got %0d want 15", o_level); end
        for (int i = 0; i < 15; i++) begin
            n_checks++; if ({l_data, r_data} !== q[0]) begin n_fail++; $display("FAIL drain_data: got %h want %h", {l_data, r_data}, q[0]); end
            tick();
        end
        l_rdy = 1'b0; r_rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] sent[$];
        int k = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = $urandom; sent.push_back(in_data);
            tick();
        end
        l_rdy = 1'b1; r_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = $urandom; sent.push_back(in_data);
            #1;
            n_checks++; if (o_level !== 5'd5) begin n_fail++; $display("FAIL b2b_level: got %0d want 5", o_level); end
            n_checks++; if ({l_data, r_data} !== sent[k]) begin n_fail++; $display("FAIL b2b_order: got %h want %h", {l_data, r_data}, sent[k]); end
            k++;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({l_data, r_data} !== sent[k]) begin n_fail++; $display("FAIL b2b_tail: got %h want %h", {l_data, r_data}, sent[k]); end
            k++;
            tick();
        end
        n_checks++; if (o_level !== 5'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d want 0", o_level); end
        l_rdy = 1'b0; r_rdy = 1'b0;
    endtask

    task automatic test_underrun();
        logic [6:0] pat;
        pat = 7'b0110111;
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        for (int i = 0; i < 7; i++) begin
            l_rdy = pat[i];
            tick();
        end
        n_checks++; if (o_underrun_cnt !== 16'd2) begin n_fail++; $display("FAIL underrun_count: got %0d want 2", o_underrun_cnt); end
        force dut.underrun_cnt_r = 16'hFFFF;
        tick();
        release dut.underrun_cnt_r;
        m_cnt = 32'hFFFF;
        tick();
        l_rdy = 1'b1;
        tick();
        tick();
        l_rdy = 1'b0;
        tick();
        n_checks++; if (o_underrun_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL underrun_saturate: got %h want ffff", o_underrun_cnt); end
    endtask

    task automatic test_flush();
        push_n(7);
        l_rdy = 1'b1;
        tick();
        l_rdy = 1'b0;
        n_checks++; if ({l_valid, r_valid} !== 2'b01) begin n_fail++; $display("FAIL flush_pre_valids: got %b want 01", {l_valid, r_valid}); end
        i_flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; l_rdy = 1'b1; r_rdy = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        n_checks++; if ({l_valid, r_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_valids: got %b want 00", {l_valid, r_valid}); end
        tick();
        i_flush = 1'b0; in_valid = 1'b0; l_rdy = 1'b0; r_rdy = 1'b0;
        #1;
        n_checks++; if (o_level !== 5'd0) begin n_fail++; $display("FAIL flush_level: got %0d want 0", o_level); end
        n_checks++; if (o_underrun_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnt: got %h want 0", o_underrun_cnt); end
        in_valid = 1'b1; in_data = 32'h0BADF00D;
        tick();
        in_valid = 1'b0;
        n_checks++; if (o_level !== 5'd1) begin n_fail++; $display("FAIL flush_repush_level: got %0d want 1", o_level); end
        n_checks++; if ({l_data, r_data} !== 32'h0BADF00D) begin n_fail++; $display("FAIL flush_not_stored: got %h want 0badf00d", {l_data, r_data}); end
        l_rdy = 1'b1; r_rdy = 1'b1;
        tick();
        l_rdy = 1'b0; r_rdy = 1'b0;
    endtask

    task automatic test_async_reset();
        push_n(9);
        #2;
        n_checks++; if (o_level !== 5'd9) begin n_fail++; $display("FAIL areset_pre_level: got %0d want 9", o_level); end
        i_rst = 1'b0;
        #1;
        model_reset();
        n_checks++; if (o_level !== 5'd0) begin n_fail++; $display("FAIL areset_level: got %0d want 0", o_level); end
        n_checks++; if ({l_valid, r_valid} !== 2'b00) begin n_fail++; $display("FAIL areset_valids: got %b want 00", {l_valid, r_valid}); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %b want 1", in_ready); end
        n_checks++; if ({l_data, r_data} !== 32'h0) begin n_fail++; $display("FAIL areset_data: got %h want 0", {l_data, r_data}); end
        i_rst = 1'b1;
        in_valid = 1'b1; in_data = 32'hCAFE1234;
        tick();
        in_valid = 1'b0;
        n_checks++; if ({l_valid, r_valid, l_data, r_data} !== {2'b11, 32'hCAFE1234}) begin n_fail++; $display("FAIL areset_first_push: got %b%b %h want 11 cafe1234", l_valid, r_valid, {l_data, r_data}); end
        l_rdy = 1'b1; r_rdy = 1'b1;
        tick();
        l_rdy = 1'b0; r_rdy = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            i_flush  = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 99) < ((i < 750) ? 70 : 20));
            in_data  = $urandom;
            l_rdy    = $urandom_range(0, 1);
            r_rdy    = $urandom_range(0, 1);
            #1;
            n_checks++; if (in_ready !== ((q.size() != DEPTH) && !i_flush)) begin n_fail++; $display("FAIL rand_in_ready: cyc %0d got %b want %b", i, in_ready, (q.size() != DEPTH) && !i_flush); end
            n_checks++; if (l_valid !== ((q.size() > 0) && !m_ld && !i_flush)) begin n_fail++; $display("FAIL rand_lvalid: cyc %0d got %b", i, l_valid); end
            n_checks++; if (r_valid !== ((q.size() > 0) && !m_rd && !i_flush)) begin n_fail++; $display("FAIL rand_rvalid: cyc %0d got %b", i, r_valid); end
            n_checks++; if (o_level !== (AW+1)'(q.size())) begin n_fail++; $display("FAIL rand_level: cyc %0d got %0d want %0d", i, o_level, q.size()); end
            n_checks++; if (o_underrun_cnt !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt: cyc %0d got %0d want %0d", i, o_underrun_cnt, m_cnt); end
            if (q.size() > 0) begin
                n_checks++; if ({l_data, r_data} !== q[0]) begin n_fail++; $display("FAIL rand_data: cyc %0d got %h want %h", i, {l_data, r_data}, q[0]); end
            end
            tick();
        end
        i_flush = 1'b0; in_valid = 1'b0; l_rdy = 1'b0; r_rdy = 1'b0;
    endtask

    initial begin
        i_rst    = 1'b0;
        i_flush  = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'h0;
        l_rdy    = 1'b0;
        r_rdy    = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_fill_split();
        test_back_to_back();
        test_underrun();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
